// File: rtl/pulse_rate_scheduler.sv
// Multi-channel periodic pulse scheduler. Each channel is a divide-by-N
// enable generator with an optional burst length. All channels share one
// configuration write port.
//
// Handshake note: there is no valid/ready flow control here. CFG_WE is a
// single-cycle write strobe that is always accepted or rejected on the edge
// where it is sampled. START, STOP and SYNC are level-sampled on every edge.
module pulse_rate_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int BURST_W     = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CFG_WE,
  input  logic [3:0]         CFG_CH,
  input  logic [CNT_W-1:0]   CFG_DIV,
  input  logic [BURST_W-1:0] CFG_BURST,
  output logic               CFG_ERR,
  input  logic [NUM_CH-1:0]  START,
  input  logic [NUM_CH-1:0]  STOP,
  input  logic               SYNC,
  output logic [NUM_CH-1:0]  PULSE,
  output logic [NUM_CH-1:0]  BUSY,
  output logic [NUM_CH-1:0]  DONE
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   DIV_RST   = CNT_W'(DEFAULT_DIV);

  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [CNT_W-1:0]   div_q   [NUM_CH];
  logic [CNT_W-1:0]   div_d   [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];
  logic [BURST_W-1:0] burst_q [NUM_CH];
  logic [BURST_W-1:0] burst_d [NUM_CH];
  logic [BURST_W-1:0] rem_q   [NUM_CH];
  logic [BURST_W-1:0] rem_d   [NUM_CH];
  logic [NUM_CH-1:0]  pulse_q, pulse_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_ok;
  logic               wr;

  // Register bank: every channel returns to IDLE with default config on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        div_q[i]   <= DIV_RST;
        cnt_q[i]   <= '0;
        burst_q[i] <= '0;
        rem_q[i]   <= '0;
      end
      pulse_q   <= '0;
      done_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        div_q[i]   <= div_d[i];
        cnt_q[i]   <= cnt_d[i];
        burst_q[i] <= burst_d[i];
        rem_q[i]   <= rem_d[i];
      end
      pulse_q   <= pulse_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state logic: config write, then per-channel FSM with STOP > SYNC > count.
  always_comb begin
    cfg_ok    = CFG_WE && (CFG_DIV != '0) && ({28'd0, CFG_CH} < NUM_CH);
    cfg_err_d = CFG_WE && !cfg_ok;
    pulse_d   = '0;
    done_d    = '0;
    wr        = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      div_d[i]   = div_q[i];
      cnt_d[i]   = cnt_q[i];
      burst_d[i] = burst_q[i];
      rem_d[i]   = rem_q[i];
      wr         = cfg_ok && (CFG_CH == 4'(i));

      if (wr) begin
        div_d[i]   = CFG_DIV;
        burst_d[i] = CFG_BURST;
      end

      case (state_q[i])
        IDLE: begin
          // A write landing on the start edge is used directly for that run.
          if (START[i] && !STOP[i]) begin
            state_d[i] = RUN;
            cnt_d[i]   = (wr ? CFG_DIV : div_q[i]) - CNT_ONE;
            rem_d[i]   = wr ? CFG_BURST : burst_q[i];
          end
        end
        RUN: begin
          if (STOP[i]) begin
            state_d[i] = IDLE;
          end else if (SYNC) begin
            cnt_d[i] = div_q[i] - CNT_ONE;
          end else if (cnt_q[i] == '0) begin
            pulse_d[i] = 1'b1;
            cnt_d[i]   = div_q[i] - CNT_ONE;
            if (burst_q[i] != '0) begin
              rem_d[i] = rem_q[i] - BURST_ONE;
              if (rem_q[i] == BURST_ONE) begin
                done_d[i]  = 1'b1;
                state_d[i] = IDLE;
              end
            end
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Status outputs come straight from registers.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      BUSY[i] = (state_q[i] == RUN);
    end
  end

  assign PULSE   = pulse_q;
  assign DONE    = done_q;
  assign CFG_ERR = cfg_err_q;

endmodule

// File: tb/tb_pulse_rate_scheduler.sv
// Directed bench for pulse_rate_scheduler: hand-computed pulse/busy/done
// patterns captured cycle by cycle and compared as bit vectors.
module tb_pulse_rate_scheduler;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic               CLK;
  logic               RST;
  logic               CFG_WE;
  logic [3:0]         CFG_CH;
  logic [CNT_W-1:0]   CFG_DIV;
  logic [BURST_W-1:0] CFG_BURST;
  logic               CFG_ERR;
  logic [NUM_CH-1:0]  START;
  logic [NUM_CH-1:0]  STOP;
  logic               SYNC;
  logic [NUM_CH-1:0]  PULSE;
  logic [NUM_CH-1:0]  BUSY;
  logic [NUM_CH-1:0]  DONE;

  int tests = 0;
  int fails = 0;

  logic [NUM_CH-1:0] p_hist [32];
  logic [NUM_CH-1:0] b_hist [32];
  logic [NUM_CH-1:0] d_hist [32];

  pulse_rate_scheduler #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W), .DEFAULT_DIV(2)
  ) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
    .CFG_DIV(CFG_DIV), .CFG_BURST(CFG_BURST), .CFG_ERR(CFG_ERR),
    .START(START), .STOP(STOP), .SYNC(SYNC),
    .PULSE(PULSE), .BUSY(BUSY), .DONE(DONE)
  );

  // Clock generation.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Record outputs now (index 0) and after each of the next n-1 edges; ends after n edges.
  task automatic cap(input int n);
    for (int j = 0; j < n; j++) begin
      p_hist[j] = PULSE;
      b_hist[j] = BUSY;
      d_hist[j] = DONE;
      tick();
    end
  endtask

  function automatic logic [31:0] pvec(input int ch, input int n);
    logic [31:0] v = '0;
    for (int j = 0; j < n; j++) v[j] = p_hist[j][ch];
    return v;
  endfunction

  function automatic logic [31:0] bvec(input int ch, input int n);
    logic [31:0] v = '0;
    for (int j = 0; j < n; j++) v[j] = b_hist[j][ch];
    return v;
  endfunction

  function automatic logic [31:0] dvec(input int ch, input int n);
    logic [31:0] v = '0;
    for (int j = 0; j < n; j++) v[j] = d_hist[j][ch];
    return v;
  endfunction

  task automatic cfg_write(input logic [3:0] ch, input logic [CNT_W-1:0] dv,
                           input logic [BURST_W-1:0] bl);
    CFG_WE = 1'b1; CFG_CH = ch; CFG_DIV = dv; CFG_BURST = bl;
    tick();
    CFG_WE = 1'b0;
  endtask

  task automatic do_start(input logic [NUM_CH-1:0] m);
    START = m;
    tick();
    START = '0;
  endtask

  task automatic do_stop(input logic [NUM_CH-1:0] m);
    STOP = m;
    tick();
    STOP = '0;
  endtask

  // Directed stimulus sequence.
  initial begin
    RST = 1'b1; CFG_WE = 1'b0; CFG_CH = '0; CFG_DIV = '0; CFG_BURST = '0;
    START = '0; STOP = '0; SYNC = 1'b0;
    tick_n(2);
    chk("rst_pulse", 32'(PULSE), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_done", 32'(DONE), 32'h0);
    chk("rst_cfg_err", 32'(CFG_ERR), 32'h0);
    RST = 1'b0;
    tick();

    // Default DIV=2 continuous on ch0.
    do_start(4'b0001);
    cap(8);
    chk("ch0_default_pulse", pvec(0, 8), 32'h54);
    chk("ch0_default_busy", bvec(0, 8), 32'hFF);
    chk("ch0_default_done", dvec(0, 8), 32'h0);
    do_stop(4'b0001);
    chk("ch0_stop_busy", 32'(BUSY[0]), 32'h0);

    // Burst of 3 at DIV=5 on ch1.
    cfg_write(4'd1, 16'd5, 8'd3);
    chk("ch1_cfg_ok", 32'(CFG_ERR), 32'h0);
    do_start(4'b0010);
    cap(20);
    chk("ch1_burst_pulse", pvec(1, 20), 32'h8420);
    chk("ch1_burst_done", dvec(1, 20), 32'h8000);
    chk("ch1_burst_busy", bvec(1, 20), 32'h7FFF);

    // Rejected writes: DIV=0 and out-of-range channel.
    cfg_write(4'd2, 16'd0, 8'd0);
    chk("err_div0", 32'(CFG_ERR), 32'h1);
    tick();
    chk("err_one_cycle", 32'(CFG_ERR), 32'h0);
    do_start(4'b0100);
    cap(6);
    chk("ch2_div_kept", pvec(2, 6), 32'h14);
    do_stop(4'b0100);
    cfg_write(4'd7, 16'd3, 8'd0);
    chk("err_bad_ch", 32'(CFG_ERR), 32'h1);

    // STOP on the edge where cnt==0 suppresses the pulse.
    cfg_write(4'd0, 16'd4, 8'd0);
    do_start(4'b0001);
    cap(5);
    chk("ch0_div4_first", pvec(0, 5), 32'h10);
    tick_n(2);
    do_stop(4'b0001);
    chk("stop_no_pulse", 32'(PULSE[0]), 32'h0);
    chk("stop_busy_low", 32'(BUSY[0]), 32'h0);
    do_start(4'b0001);
    cap(6);
    chk("ch0_restart_latency", pvec(0, 6), 32'h10);
    do_stop(4'b0001);

    // SYNC realigns ch0 (DIV=3) and ch3 (DIV=7); it lands where ch0 would pulse.
    cfg_write(4'd0, 16'd3, 8'd0);
    cfg_write(4'd3, 16'd7, 8'd0);
    do_start(4'b1001);
    tick_n(2);
    SYNC = 1'b1;
    tick();
    SYNC = 1'b0;
    chk("sync_no_pulse", 32'(PULSE), 32'h0);
    cap(15);
    chk("sync_ch0", pvec(0, 15), 32'h1248);
    chk("sync_ch3", pvec(3, 15), 32'h4080);
    do_stop(4'b1001);

    // Divider change on a running channel completes the current period first.
    do_start(4'b0001);
    cap(4);
    chk("ch0_div3_pre", pvec(0, 4), 32'h08);
    cfg_write(4'd0, 16'd6, 8'd0);
    cap(14);
    chk("ch0_div_change", pvec(0, 14), 32'h2082);
    do_stop(4'b0001);

    // START and STOP together on an idle channel keeps it idle.
    START = 4'b0100; STOP = 4'b0100;
    tick();
    START = '0; STOP = '0;
    cap(4);
    chk("start_stop_busy", bvec(2, 4), 32'h0);
    chk("start_stop_pulse", pvec(2, 4), 32'h0);

    // Write and START on the same edge use the written values.
    CFG_WE = 1'b1; CFG_CH = 4'd2; CFG_DIV = 16'd3; CFG_BURST = 8'd2;
    START = 4'b0100;
    tick();
    CFG_WE = 1'b0; START = '0;
    cap(8);
    chk("bypass_pulse", pvec(2, 8), 32'h48);
    chk("bypass_done", dvec(2, 8), 32'h40);
    chk("bypass_busy", bvec(2, 8), 32'h3F);

    // Asynchronous reset mid-run clears BUSY without waiting for an edge.
    do_start(4'b0010);
    tick_n(2);
    RST = 1'b1;
    #1;
    chk("async_rst_busy", 32'(BUSY), 32'h0);
    chk("async_rst_done", 32'(DONE), 32'h0);
    tick();
    RST = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pulse_rate_scheduler.md
Name: pulse_rate_scheduler

Overview:
- Multi-channel scheduler for periodic enable pulses. Shares one configuration port across NUM_CH programmable divide-by-N pulse generators.
- Each channel runs continuously or for a fixed burst of pulses, and is started, stopped and realigned independently.
- Sequences the filter pipeline stages, e.g. predict/update/resample, each from its own clock-enable rate off the single system CLK.

Parameters:
NUM_CH, 4, number of pulse channels (1..16)
CNT_W, 16, width of divide ratio and period counter
BURST_W, 8, width of burst-length field
DEFAULT_DIV, 2, divide ratio loaded at reset (must be >=1)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  asynchronous, active-high reset
CFG_WE  in  1  configuration write strobe
CFG_CH  in  4  target channel index for write
CFG_DIV  in  CNT_W  divide ratio N (pulse every N cycles)
CFG_BURST  in  BURST_W  pulses per run; 0 = continuous
CFG_ERR  out  1  one-cycle flag: last write rejected
START  in  NUM_CH  per-channel start request
STOP  in  NUM_CH  per-channel stop request
SYNC  in  1  realign phase of all running channels
PULSE  out  NUM_CH  registered one-cycle enable pulses
BUSY  out  NUM_CH  channel in RUN state
DONE  out  NUM_CH  one-cycle flag: burst completed

Behaviour:
- Reset (async, RST high):
  - PULSE, BUSY, DONE and CFG_ERR are 0.
  - Every channel is IDLE, with div_reg=DEFAULT_DIV, burst_reg=0, cnt=0, remaining=0.
- Per-channel FSM has two states, IDLE and RUN. BUSY = (state==RUN), taken from the state register.
- IDLE -> RUN on START[i]. At that edge: cnt <= div_reg-1, remaining <= burst_reg.
- RUN, each edge:
  - If cnt==0: PULSE[i] <= 1, cnt <= div_reg-1. If burst_reg!=0: remaining <= remaining-1.
  - Otherwise: cnt <= cnt-1, PULSE[i] <= 0.
- Latency: with START sampled at edge k, PULSE is high during the cycle after edge k+N. Later pulses follow every N cycles, each lasting exactly one cycle. N=1 gives PULSE high every cycle.
- Burst end: when a pulse fires with burst_reg!=0 and remaining==1:
  - DONE[i] <= 1 in the same cycle as that final PULSE.
  - State goes to IDLE. Exactly burst_reg pulses are emitted.
- STOP[i] in RUN: go to IDLE at that edge, with no pulse and no DONE, even if cnt==0 on that edge. STOP in IDLE has no effect.
- START and STOP both asserted on the same edge: STOP wins.
- START while in RUN is ignored; phase and remaining are unchanged.
- SYNC: every channel in RUN reloads cnt <= div_reg-1 and emits no pulse on that edge. remaining is unchanged. Channels in IDLE are unaffected.
- SYNC together with STOP on the same channel: STOP wins.
- Config write (CFG_WE=1):
  - Rejected if CFG_DIV==0 or CFG_CH>=NUM_CH. On reject: CFG_ERR <= 1 for one cycle and no register changes.
  - Otherwise div_reg and burst_reg are updated.
- Effect of a write depends on channel state:
  - IDLE channel: the new values apply to the next START.
  - RUN channel: the new div applies at the next reload (pulse or SYNC); the current period completes.
  - A new burst on a RUN channel takes effect only at the next START; remaining is not reloaded.
- Write and START to the same channel on the same edge: the new CFG_DIV/CFG_BURST are used directly for that start (bypass).
- Counters wrap-free: cnt is loaded only with div_reg-1 and div_reg>=1 is guaranteed, so no underflow.
- Reset asserted mid-run: all channels return to IDLE immediately and asynchronously. No DONE is emitted.

Test Plan:
- Reset, then START[0] at edge k with default DIV=2, BURST=0 -> PULSE[0] high during cycles after edges k+2, k+4, k+6...; BUSY[0]=1; DONE stays 0.
- Write ch1 DIV=5, BURST=3, then START[1] -> exactly 3 pulses spaced 5 cycles apart, first 5 cycles after START. DONE[1] coincides with the 3rd pulse; BUSY[1] drops after it.
- Write ch2 DIV=0 -> CFG_ERR high for one cycle; div_reg stays 2. Write CFG_CH=7 -> CFG_ERR again.
- Ch0 running at DIV=4, assert STOP[0] on the edge where cnt==0 -> no pulse. BUSY falls; a later START restarts with full 4-cycle latency.
- Ch0 at DIV=3 and ch3 at DIV=7 running, pulse SYNC -> both emit their next pulse exactly DIV cycles after SYNC and stay phase-aligned to it.
- Ch0 running at DIV=3, write DIV=6 -> current period finishes at 3, subsequent pulses spaced 6. START and STOP asserted together on an idle channel -> stays IDLE.
